// File: rtl/alu1_pkg.sv
// Shared ALU1 definitions: operation encoding, stimulus FSM states and LFSR constants.
// Used by the ALU1 datapath, its checker and the stimulus generator.
package alu1_pkg;

    typedef enum logic [3:0] {
        ALU1_OP_TRANSFER   = 4'd0,
        ALU1_OP_INC        = 4'd1,
        ALU1_OP_ADD        = 4'd2,
        ALU1_OP_ADD_PLUS1  = 4'd3,
        ALU1_OP_SUB_MINUS1 = 4'd4,
        ALU1_OP_SUB        = 4'd5,
        ALU1_OP_DEC        = 4'd6,
        ALU1_OP_TRANSFER2  = 4'd7,
        ALU1_OP_AND        = 4'd8,
        ALU1_OP_OR         = 4'd9,
        ALU1_OP_XOR        = 4'd10,
        ALU1_OP_NOT        = 4'd11
    } alu1_op_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CORNER = 2'd1,
        ST_RANDOM = 2'd2,
        ST_DONE   = 2'd3
    } stim_state_t;

    localparam int          ALU1_NUM_OPS      = 12;
    localparam int          ALU1_CORNER_PAIRS = 4;
    localparam logic [63:0] ALU1_LFSR_MASK    = 64'hD800_0000_0000_0000;
    localparam logic [63:0] ALU1_PAT_55       = 64'h5555_5555_5555_5555;
    localparam logic [63:0] ALU1_PAT_AA       = 64'hAAAA_AAAA_AAAA_AAAA;

endpackage

// File: rtl/alu1_lfsr64.sv
// Combinational single and double step of the 64-bit Galois right-shift LFSR.
module alu1_lfsr64
    import alu1_pkg::*;
(
    input  logic [63:0] state_i,
    output logic [63:0] step1_o,
    output logic [63:0] step2_o
);

    function automatic logic [63:0] lfsr_step(input logic [63:0] s);
        return s[0] ? ((s >> 1) ^ ALU1_LFSR_MASK) : (s >> 1);
    endfunction

    always_comb begin
        step1_o = lfsr_step(state_i);
        step2_o = lfsr_step(step1_o);
    end

endmodule

// File: rtl/alu1_stim_gen.sv
// ALU1 stimulus source: 48-vector corner sweep followed by NUM_TXN LFSR-driven
// transactions on a valid/ready interface.
module alu1_stim_gen
    import alu1_pkg::*;
#(
    parameter int          WIDTH   = 64,
    parameter int          NUM_TXN = 1024,
    parameter logic [63:0] SEED    = 64'h1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             out_valid,
    input  logic             out_ready,
    output alu1_op_t         op,
    output logic [WIDTH-1:0] in1,
    output logic [WIDTH-1:0] in2,
    output logic             busy,
    output logic             done,
    output logic [31:0]      txn_count
);

    localparam logic [3:0]       LAST_OP   = 4'(ALU1_NUM_OPS - 1);
    localparam logic [1:0]       LAST_PAIR = 2'(ALU1_CORNER_PAIRS - 1);
    localparam logic [31:0]      LAST_RND  = 32'(NUM_TXN - 1);
    localparam logic [WIDTH-1:0] ONE       = WIDTH'(1);
    localparam logic [WIDTH-1:0] MSB_ONLY  = {1'b1, {(WIDTH-1){1'b0}}};

    stim_state_t state_q, state_d;
    logic [1:0]  pair_q, pair_d;
    logic [3:0]  cop_q, cop_d;
    logic [3:0]  op_idx_q, op_idx_d;
    logic [63:0] lfsr_q, lfsr_d;
    logic [31:0] rnd_cnt_q, rnd_cnt_d;
    logic [31:0] txn_count_q, txn_count_d;
    logic [63:0] step1, step2;
    logic        accept;

    alu1_lfsr64 u_lfsr (
        .state_i (lfsr_q),
        .step1_o (step1),
        .step2_o (step2)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            pair_q      <= '0;
            cop_q       <= '0;
            op_idx_q    <= '0;
            lfsr_q      <= SEED;
            rnd_cnt_q   <= '0;
            txn_count_q <= '0;
        end else begin
            state_q     <= state_d;
            pair_q      <= pair_d;
            cop_q       <= cop_d;
            op_idx_q    <= op_idx_d;
            lfsr_q      <= lfsr_d;
            rnd_cnt_q   <= rnd_cnt_d;
            txn_count_q <= txn_count_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        pair_d      = pair_q;
        cop_d       = cop_q;
        op_idx_d    = op_idx_q;
        lfsr_d      = lfsr_q;
        rnd_cnt_d   = rnd_cnt_q;
        txn_count_d = txn_count_q;
        accept      = out_valid && out_ready;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d     = ST_CORNER;
                    pair_d      = '0;
                    cop_d       = '0;
                    op_idx_d    = '0;
                    lfsr_d      = SEED;
                    rnd_cnt_d   = '0;
                    txn_count_d = '0;
                end
            end
            ST_CORNER: begin
                if (accept) begin
                    if (cop_q == LAST_OP) begin
                        cop_d = '0;
                        if (pair_q == LAST_PAIR) begin
                            state_d   = ST_RANDOM;
                            rnd_cnt_d = '0;
                        end else begin
                            pair_d = pair_q + 2'd1;
                        end
                    end else begin
                        cop_d = cop_q + 4'd1;
                    end
                end
            end
            ST_RANDOM: begin
                if (accept) begin
                    lfsr_d = step2;
                    // stride 5 is coprime to 12, so every op appears once per 12 txns
                    op_idx_d  = (op_idx_q >= 4'd7) ? (op_idx_q - 4'd7) : (op_idx_q + 4'd5);
                    rnd_cnt_d = rnd_cnt_q + 32'd1;
                    if (rnd_cnt_q == LAST_RND) begin
                        state_d = ST_DONE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (accept && (txn_count_q != '1)) begin
            txn_count_d = txn_count_q + 32'd1;
        end
    end

    always_comb begin
        out_valid = (state_q == ST_CORNER) || (state_q == ST_RANDOM);
        busy      = out_valid;
        done      = (state_q == ST_DONE);
        txn_count = txn_count_q;
        op        = ALU1_OP_TRANSFER;
        in1       = '0;
        in2       = '0;

        if (state_q == ST_CORNER) begin
            op = alu1_op_t'(cop_q);
            case (pair_q)
                2'd0: begin in1 = '0;                       in2 = '0;                       end
                2'd1: begin in1 = '1;                       in2 = ONE;                      end
                2'd2: begin in1 = MSB_ONLY;                 in2 = '1;                       end
                default: begin in1 = ALU1_PAT_55[WIDTH-1:0]; in2 = ALU1_PAT_AA[WIDTH-1:0]; end
            endcase
        end else if (state_q == ST_RANDOM) begin
            op  = alu1_op_t'(op_idx_q);
            in1 = lfsr_q[WIDTH-1:0];
            in2 = step1[WIDTH-1:0];
        end
    end

endmodule

// File: tb/tb_alu1_stim_gen.sv
// Bench for alu1_stim_gen: two instances (64-bit/20 txns and 16-bit/1 txn) compared
// against a transaction-index reference model under steady and random back-pressure.
module tb_alu1_stim_gen;
    import alu1_pkg::*;

    localparam logic [63:0] SEED_A = 64'h1;
    localparam logic [63:0] SEED_B = 64'h1234_5678_9ABC_DEF1;
    localparam int          N_A    = 20;
    localparam int          N_B    = 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic start_r;
    logic ready_r;
    int   sel;
    int   total = 0;
    int   bad   = 0;

    logic        a_start, a_ready, a_valid, a_busy, a_done;
    alu1_op_t    a_op;
    logic [63:0] a_in1, a_in2;
    logic [31:0] a_cnt;

    logic        b_start, b_ready, b_valid, b_busy, b_done;
    alu1_op_t    b_op;
    logic [15:0] b_in1, b_in2;
    logic [31:0] b_cnt;

    assign a_start = start_r && (sel == 0);
    assign a_ready = ready_r && (sel == 0);
    assign b_start = start_r && (sel == 1);
    assign b_ready = ready_r && (sel == 1);

    alu1_stim_gen #(.WIDTH(64), .NUM_TXN(N_A), .SEED(SEED_A)) dut (
        .clk(clk), .rst(rst), .start(a_start), .out_valid(a_valid), .out_ready(a_ready),
        .op(a_op), .in1(a_in1), .in2(a_in2), .busy(a_busy), .done(a_done), .txn_count(a_cnt)
    );

    alu1_stim_gen #(.WIDTH(16), .NUM_TXN(N_B), .SEED(SEED_B)) dut_b (
        .clk(clk), .rst(rst), .start(b_start), .out_valid(b_valid), .out_ready(b_ready),
        .op(b_op), .in1(b_in1), .in2(b_in2), .busy(b_busy), .done(b_done), .txn_count(b_cnt)
    );

    logic        s_valid, s_busy, s_done;
    logic [63:0] s_op, s_in1, s_in2;
    logic [31:0] s_cnt;
    assign s_valid = (sel == 1) ? b_valid : a_valid;
    assign s_busy  = (sel == 1) ? b_busy  : a_busy;
    assign s_done  = (sel == 1) ? b_done  : a_done;
    assign s_op    = (sel == 1) ? 64'(b_op) : 64'(a_op);
    assign s_in1   = (sel == 1) ? {48'd0, b_in1} : a_in1;
    assign s_in2   = (sel == 1) ? {48'd0, b_in2} : a_in2;
    assign s_cnt   = (sel == 1) ? b_cnt : a_cnt;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] lstep(input logic [63:0] s);
        return s[0] ? ((s >> 1) ^ 64'hD800_0000_0000_0000) : (s >> 1);
    endfunction

    // Expected transaction number k of a run, straight from the sweep and LFSR rules.
    function automatic void model_txn(input int width, input logic [63:0] seed, input int k,
                                      output logic [63:0] eop, output logic [63:0] ea,
                                      output logic [63:0] eb);
        logic [63:0] mask;
        logic [63:0] s;
        int          r;
        mask = (width == 64) ? {64{1'b1}} : ((64'd1 << width) - 64'd1);
        if (k < 48) begin
            eop = 64'(k % 12);
            case (k / 12)
                0:       begin ea = 64'd0;                      eb = 64'd0;                      end
                1:       begin ea = mask;                       eb = 64'd1;                      end
                2:       begin ea = 64'd1 << (width - 1);       eb = mask;                       end
                default: begin ea = 64'h5555_5555_5555_5555 & mask; eb = 64'hAAAA_AAAA_AAAA_AAAA & mask; end
            endcase
        end else begin
            r = k - 48;
            s = seed;
            for (int i = 0; i < r; i++) s = lstep(lstep(s));
            eop = 64'((5 * r) % 12);
            ea  = s & mask;
            eb  = lstep(s) & mask;
        end
    endfunction

    task automatic chk_reset(input string tag);
        chk({tag, "_valid"}, 64'(s_valid), 64'd0);
        chk({tag, "_op"},    s_op,         64'd0);
        chk({tag, "_in1"},   s_in1,        64'd0);
        chk({tag, "_in2"},   s_in2,        64'd0);
        chk({tag, "_busy"},  64'(s_busy),  64'd0);
        chk({tag, "_done"},  64'(s_done),  64'd0);
        chk({tag, "_cnt"},   64'(s_cnt),   64'd0);
    endtask

    // One run from start pulse to done; optional start-while-busy and mid-run reset.
    task automatic run(input int w, input logic [63:0] seed, input int n, input bit rand_ready,
                       input int busy_start_k, input int rst_k);
        int          k;
        int          cyc;
        bit          pulsed;
        logic [63:0] eop, ea, eb;
        k      = 0;
        cyc    = 0;
        pulsed = 1'b0;
        @(negedge clk);
        chk("pre_start_valid", 64'(s_valid), 64'd0);
        start_r = 1'b1;
        ready_r = 1'b1;
        @(negedge clk);
        start_r = 1'b0;
        while ((k < n + 48) && (cyc < 4000)) begin
            model_txn(w, seed, k, eop, ea, eb);
            chk("valid", 64'(s_valid), 64'd1);
            chk("cnt",   64'(s_cnt),   64'(k));
            chk("op",    s_op,  eop);
            chk("in1",   s_in1, ea);
            chk("in2",   s_in2, eb);
            if (k == rst_k) begin
                ready_r = 1'b0;
                #2;
                rst = 1'b1;
                #1;
                chk_reset("midrun_rst");
                @(negedge clk);
                rst = 1'b0;
                return;
            end
            if ((k == busy_start_k) && !pulsed) begin
                start_r = 1'b1;
                pulsed  = 1'b1;
            end else begin
                start_r = 1'b0;
            end
            ready_r = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (ready_r) k++;
            cyc++;
            @(negedge clk);
        end
        start_r = 1'b0;
        chk("run_len", 64'(k), 64'(n + 48));
        chk("end_done",  64'(s_done),  64'd1);
        chk("end_valid", 64'(s_valid), 64'd0);
        chk("end_busy",  64'(s_busy),  64'd0);
        chk("end_cnt",   64'(s_cnt),   64'(n + 48));
        repeat (3) @(negedge clk);
        chk("hold_done", 64'(s_done),  64'd1);
        chk("hold_cnt",  64'(s_cnt),   64'(n + 48));
    endtask

    initial begin
        rst     = 1'b1;
        start_r = 1'b0;
        ready_r = 1'b1;
        sel     = 0;
        repeat (2) @(negedge clk);
        chk_reset("rst_a");
        sel = 1;
        #1;
        chk_reset("rst_b");
        sel = 0;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("idle_ready_valid", 64'(s_valid), 64'd0);
        chk("idle_ready_cnt",   64'(s_cnt),   64'd0);

        run(64, SEED_A, N_A, 1'b0, -1, -1);
        run(64, SEED_A, N_A, 1'b1, -1, -1);
        run(64, SEED_A, N_A, 1'b1, 30, -1);
        run(64, SEED_A, N_A, 1'b1, -1, 55);
        run(64, SEED_A, N_A, 1'b0, -1, -1);

        sel = 1;
        #1;
        chk("b_idle_valid", 64'(s_valid), 64'd0);
        run(16, SEED_B, N_B, 1'b0, -1, -1);
        run(16, SEED_B, N_B, 1'b1, -1, -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
